// File: rtl/hazard_unit_if.sv
// Hazard-unit bundle: ID-stage instruction fields and the MEM branch outcome
// flowing in, and the decoder bubble plus pipeline-steering strobes flowing out.
// The pipeline side uses the master modport; hazard_unit uses the slave modport.
interface hazard_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) ();
    logic [5:0]       id_opcode;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] id_rd;
    logic             mem_br_taken;
    logic             hazard;
    logic             pc_write;
    logic             ifid_write;
    logic             flush_ifid;
    logic             flush_exmem;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_opcode, id_rs, id_rt, id_rd, mem_br_taken,
        input  hazard, pc_write, ifid_write, flush_ifid, flush_exmem, stall_cnt
    );

    modport slave (
        input  id_opcode, id_rs, id_rt, id_rd, mem_br_taken,
        output hazard, pc_write, ifid_write, flush_ifid, flush_exmem, stall_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall and taken-branch flush control for the 5-stage
// MIPS core. Keeps a private shadow of ID/EX {is_load, is_br, dst} and of
// EX/MEM {is_br}. The strobes are combinational from the shadows and the
// current ID fields, so they are valid in the same cycle.
// Optional feature: define HAZ_STALL_CNT_EN to build the saturating
// hazard-cycle counter on stall_cnt. Without it, stall_cnt is tied to zero.
module hazard_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    hazard_unit_if.slave hz
);

    localparam logic [5:0]       OP_RTYPE = 6'b000000;
    localparam logic [5:0]       OP_LW    = 6'b100011;
    localparam logic [5:0]       OP_SW    = 6'b101011;
    localparam logic [5:0]       OP_BEQ   = 6'b000100;
    localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};

    typedef struct packed {
        logic             is_load;
        logic             is_br;
        logic             uses_rs;
        logic             uses_rt;
        logic [REG_W-1:0] dst;
    } id_dec_t;

    // Opcode class decode; unknown opcodes look like a bubble (no dst, no sources).
    function automatic id_dec_t decode(input logic [5:0]       op,
                                       input logic [REG_W-1:0] rt,
                                       input logic [REG_W-1:0] rd);
        id_dec_t d;
        d.is_load = 1'b0;
        d.is_br   = 1'b0;
        d.uses_rs = 1'b0;
        d.uses_rt = 1'b0;
        d.dst     = REG_ZERO;
        case (op)
            OP_RTYPE: begin
                d.uses_rs = 1'b1;
                d.uses_rt = 1'b1;
                d.dst     = rd;
            end
            OP_LW: begin
                d.is_load = 1'b1;
                d.uses_rs = 1'b1;
                d.dst     = rt;
            end
            OP_SW: begin
                d.uses_rs = 1'b1;
                d.uses_rt = 1'b1;
            end
            OP_BEQ: begin
                d.is_br   = 1'b1;
                d.uses_rs = 1'b1;
                d.uses_rt = 1'b1;
            end
            default: begin
                d.is_load = 1'b0;
                d.is_br   = 1'b0;
                d.uses_rs = 1'b0;
                d.uses_rt = 1'b0;
                d.dst     = REG_ZERO;
            end
        endcase
        return d;
    endfunction

    // Shadow pipeline state
    logic             ex_is_load_r;
    logic             ex_is_br_r;
    logic [REG_W-1:0] ex_dst_r;
    logic             mem_is_br_r;

    id_dec_t dec_s;
    logic    load_use_s;
    logic    flush_s;
    logic    hazard_s;
    logic    pc_write_s;
    logic    ifid_write_s;
    logic    flush_ifid_s;
    logic    flush_exmem_s;

    // Hazard detection: load-use against the EX shadow, taken branch against the MEM shadow.
    always_comb begin
        dec_s      = decode(hz.id_opcode, hz.id_rt, hz.id_rd);
        load_use_s = ex_is_load_r && (ex_dst_r != REG_ZERO) &&
                     ((dec_s.uses_rs && (ex_dst_r == hz.id_rs)) ||
                      (dec_s.uses_rt && (ex_dst_r == hz.id_rt)));
        flush_s    = hz.mem_br_taken && mem_is_br_r;
    end

    // Steering strobes: reset forces RUN values, then flush outranks stall.
    always_comb begin
        hazard_s      = 1'b0;
        pc_write_s    = 1'b1;
        ifid_write_s  = 1'b1;
        flush_ifid_s  = 1'b0;
        flush_exmem_s = 1'b0;
        if (reset) begin
            hazard_s      = 1'b0;
            pc_write_s    = 1'b1;
            ifid_write_s  = 1'b1;
            flush_ifid_s  = 1'b0;
            flush_exmem_s = 1'b0;
        end else if (flush_s) begin
            // Wrong-path instructions are discarded; PC loads the branch target.
            hazard_s      = 1'b1;
            pc_write_s    = 1'b1;
            ifid_write_s  = 1'b1;
            flush_ifid_s  = 1'b1;
            flush_exmem_s = 1'b1;
        end else if (load_use_s) begin
            hazard_s      = 1'b1;
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            flush_ifid_s  = 1'b0;
            flush_exmem_s = 1'b0;
        end else begin
            hazard_s      = 1'b0;
            pc_write_s    = 1'b1;
            ifid_write_s  = 1'b1;
            flush_ifid_s  = 1'b0;
            flush_exmem_s = 1'b0;
        end
    end

    // Advance the shadows; a stall or flush injects a bubble so neither can repeat.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_is_load_r <= 1'b0;
            ex_is_br_r   <= 1'b0;
            ex_dst_r     <= REG_ZERO;
            mem_is_br_r  <= 1'b0;
        end else if (flush_s) begin
            ex_is_load_r <= 1'b0;
            ex_is_br_r   <= 1'b0;
            ex_dst_r     <= REG_ZERO;
            mem_is_br_r  <= 1'b0;
        end else if (load_use_s) begin
            ex_is_load_r <= 1'b0;
            ex_is_br_r   <= 1'b0;
            ex_dst_r     <= REG_ZERO;
            mem_is_br_r  <= ex_is_br_r;
        end else begin
            ex_is_load_r <= dec_s.is_load;
            ex_is_br_r   <= dec_s.is_br;
            ex_dst_r     <= dec_s.dst;
            mem_is_br_r  <= ex_is_br_r;
        end
    end

    assign hz.hazard      = hazard_s;
    assign hz.pc_write    = pc_write_s;
    assign hz.ifid_write  = ifid_write_s;
    assign hz.flush_ifid  = flush_ifid_s;
    assign hz.flush_exmem = flush_exmem_s;

`ifdef HAZ_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_r;

    // Count every hazard cycle (stall or flush), holding at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (hazard_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign hz.stall_cnt = stall_cnt_r;
`else
    assign hz.stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a per-cycle vector table with hand-computed
// strobes, followed by hand-written reset-mid-stall and reset-mid-flush
// sequences. The counter is built narrow so that saturation is reached.
module tb_hazard_unit;

    localparam int REG_W = 5;
    localparam int CNT_W = 2;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;

    // {hazard, pc_write, ifid_write, flush_ifid, flush_exmem}
    localparam logic [4:0] RUN   = 5'b01100;
    localparam logic [4:0] STALL = 5'b10000;
    localparam logic [4:0] FLUSH = 5'b11111;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       br;
        logic [4:0] exp;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    hazard_unit_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (bus)
    );

    always #5 clk = ~clk;

    int               n_cmp = 0;
    int               n_bad = 0;
    logic [CNT_W-1:0] cnt_model = '0;
    vec_t             tbl[$];

    function automatic vec_t mk(input logic rst, input logic [5:0] op,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic br,
                                input logic [4:0] exp, input string name);
        vec_t v;
        v.rst = rst; v.op = op; v.rs = rs; v.rt = rt; v.rd = rd;
        v.br = br; v.exp = exp; v.name = name;
        return v;
    endfunction

    // Drive one cycle (called #1 after posedge), check at negedge, advance the counter model.
    task automatic apply(input vec_t v, input bit chk_cnt);
        logic [4:0]       got;
        logic [CNT_W-1:0] exp_cnt;
        reset            = v.rst;
        bus.id_opcode    = v.op;
        bus.id_rs        = v.rs;
        bus.id_rt        = v.rt;
        bus.id_rd        = v.rd;
        bus.mem_br_taken = v.br;
        @(negedge clk);
        got = {bus.hazard, bus.pc_write, bus.ifid_write, bus.flush_ifid, bus.flush_exmem};
        n_cmp++;
        if (got !== v.exp) begin
            n_bad++;
            $display("FAIL %s strobes got=%b want=%b", v.name, got, v.exp);
        end
`ifdef HAZ_STALL_CNT_EN
        exp_cnt = cnt_model;
`else
        exp_cnt = '0;
`endif
        if (chk_cnt) begin
            n_cmp++;
            if (bus.stall_cnt !== exp_cnt) begin
                n_bad++;
                $display("FAIL %s stall_cnt got=%0d want=%0d", v.name, bus.stall_cnt, exp_cnt);
            end
        end
        @(posedge clk);
        #1;
        if (v.rst) cnt_model = '0;
        else if (v.exp[4] && (cnt_model != {CNT_W{1'b1}})) cnt_model = cnt_model + 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        bus.id_opcode = OP_R; bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
        bus.mem_br_taken = 1'b0;

        // Each row is one cycle; shadows carry from row to row.
        tbl.push_back(mk(1'b1, OP_R,   5'd0, 5'd0, 5'd0, 1'b0, RUN,   "t1_reset0"));
        tbl.push_back(mk(1'b1, OP_R,   5'd0, 5'd0, 5'd0, 1'b0, RUN,   "t1_reset1"));
        tbl.push_back(mk(1'b0, OP_R,   5'd0, 5'd0, 5'd0, 1'b0, RUN,   "t1_nop"));
        tbl.push_back(mk(1'b0, OP_LW,  5'd1, 5'd5, 5'd0, 1'b0, RUN,   "t2_lw5"));
        tbl.push_back(mk(1'b0, OP_R,   5'd5, 5'd2, 5'd7, 1'b0, STALL, "t2_add_stall"));
        tbl.push_back(mk(1'b0, OP_R,   5'd5, 5'd2, 5'd7, 1'b0, RUN,   "t2_add_release"));
        tbl.push_back(mk(1'b0, OP_LW,  5'd1, 5'd5, 5'd0, 1'b0, RUN,   "t3_lw5_a"));
        tbl.push_back(mk(1'b0, OP_SW,  5'd3, 5'd5, 5'd0, 1'b0, STALL, "t3_sw_rt_stall"));
        tbl.push_back(mk(1'b0, OP_SW,  5'd3, 5'd5, 5'd0, 1'b0, RUN,   "t3_sw_release"));
        tbl.push_back(mk(1'b0, OP_LW,  5'd1, 5'd5, 5'd0, 1'b0, RUN,   "t3_lw5_b"));
        tbl.push_back(mk(1'b0, OP_LW,  5'd5, 5'd6, 5'd0, 1'b0, STALL, "t3_lw_rs_stall"));
        tbl.push_back(mk(1'b0, OP_LW,  5'd5, 5'd6, 5'd0, 1'b0, RUN,   "t3_lw_release"));
        tbl.push_back(mk(1'b0, OP_LW,  5'd2, 5'd5, 5'd0, 1'b0, RUN,   "t3_lw5_c"));
        tbl.push_back(mk(1'b0, OP_LW,  5'd2, 5'd5, 5'd0, 1'b0, RUN,   "t3_lw_rt_unused"));
        tbl.push_back(mk(1'b0, OP_R,   5'd0, 5'd0, 5'd0, 1'b0, RUN,   "t4_nop_after_lw"));
        tbl.push_back(mk(1'b0, OP_R,   5'd5, 5'd5, 5'd8, 1'b0, RUN,   "t4_load_in_mem"));
        tbl.push_back(mk(1'b0, OP_LW,  5'd1, 5'd0, 5'd0, 1'b0, RUN,   "t4_lw0"));
        tbl.push_back(mk(1'b0, OP_R,   5'd0, 5'd0, 5'd1, 1'b0, RUN,   "t4_use_r0"));
        tbl.push_back(mk(1'b0, OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b0, RUN,   "t5_beq_id"));
        tbl.push_back(mk(1'b0, OP_R,   5'd0, 5'd0, 5'd0, 1'b0, RUN,   "t5_beq_ex"));
        tbl.push_back(mk(1'b0, OP_R,   5'd0, 5'd0, 5'd0, 1'b1, FLUSH, "t5_flush"));
        tbl.push_back(mk(1'b0, OP_R,   5'd0, 5'd0, 5'd0, 1'b0, RUN,   "t5_after_flush"));
        tbl.push_back(mk(1'b0, OP_R,   5'd0, 5'd0, 5'd0, 1'b1, RUN,   "t5_taken_no_beq"));
        tbl.push_back(mk(1'b0, OP_BEQ, 5'd3, 5'd4, 5'd0, 1'b0, RUN,   "t5_beq2_id"));
        tbl.push_back(mk(1'b0, OP_R,   5'd0, 5'd0, 5'd0, 1'b0, RUN,   "t5_beq2_ex"));
        tbl.push_back(mk(1'b0, OP_R,   5'd0, 5'd0, 5'd0, 1'b0, RUN,   "t5_beq2_not_taken"));
        tbl.push_back(mk(1'b0, OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b0, RUN,   "t6_beq_id"));
        tbl.push_back(mk(1'b0, OP_LW,  5'd1, 5'd5, 5'd0, 1'b0, RUN,   "t6_lw5"));
        tbl.push_back(mk(1'b0, OP_R,   5'd5, 5'd2, 5'd7, 1'b1, FLUSH, "t6_flush_over_stall"));
        tbl.push_back(mk(1'b0, OP_R,   5'd5, 5'd2, 5'd7, 1'b0, RUN,   "t6_after_flush"));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i > 0);
        end

        // Hand-written: reset arrives while a load-use stall is pending.
        apply(mk(1'b0, OP_LW, 5'd1, 5'd5, 5'd0, 1'b0, RUN,   "r_stall_lw5"), 1'b1);
        apply(mk(1'b1, OP_R,  5'd5, 5'd2, 5'd7, 1'b0, RUN,   "r_stall_reset"), 1'b1);
        apply(mk(1'b0, OP_R,  5'd5, 5'd2, 5'd7, 1'b0, RUN,   "r_stall_after"), 1'b1);

        // Hand-written: reset arrives in the cycle the branch would flush.
        apply(mk(1'b0, OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b0, RUN,  "r_flush_beq"), 1'b1);
        apply(mk(1'b0, OP_R,   5'd0, 5'd0, 5'd0, 1'b0, RUN,  "r_flush_ex"), 1'b1);
        apply(mk(1'b1, OP_R,   5'd0, 5'd0, 5'd0, 1'b1, RUN,  "r_flush_reset"), 1'b1);
        apply(mk(1'b0, OP_R,   5'd0, 5'd0, 5'd0, 1'b1, RUN,  "r_flush_after"), 1'b1);
        apply(mk(1'b0, OP_LW,  5'd1, 5'd5, 5'd0, 1'b0, RUN,  "r_lw5"), 1'b1);
        apply(mk(1'b0, OP_R,   5'd2, 5'd5, 5'd9, 1'b0, STALL, "r_stall_counts"), 1'b1);
        apply(mk(1'b0, OP_R,   5'd2, 5'd5, 5'd9, 1'b0, RUN,  "r_final"), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
